mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter between the instruction-fetch path and the load/store data path of the CPU. Both requesters share one 256×16 synchronous-read RAM. Each access gets a registered grant and, for reads, a registered one-cycle response. Data requests win by default; an optional starvation guard bounds how long fetch can be held off. The block sits between the CPU controller/datapath and the RAM, replacing direct RAM address muxing.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width
- STARVE_LIMIT, 4, consecutive lost contested arbitrations after which fetch is forced to win (guard builds only)

- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- f_req  in  1  fetch read request; hold with f_addr stable until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch access accepted (one-cycle pulse)
- f_rvalid  out  1  f_rdata valid (one-cycle pulse)
- f_rdata  out  DATA_W  fetch read data; holds last value
- d_req  in  1  data request; hold with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data access accepted (one-cycle pulse)
- d_rvalid  out  1  d_rdata valid (reads only, one-cycle pulse)
- d_rdata  out  DATA_W  data read data; holds last value
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_w_en  out  1  RAM write enable
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_addr is presented

## Operation
- States:
  - IDLE: no access in flight.
  - F_ACC: fetch read driving RAM.
  - D_RD: data read driving RAM.
  - D_WR: data write.
  - F_RESP: returns fetch read data.
  - D_RESP: returns data read data.
- Arbitration decision is taken at the end of IDLE, F_RESP, D_RESP and D_WR cycles only. Requests are ignored in F_ACC and D_RD.
- Decision:
  - d_req → D_WR if d_we, else D_RD.
  - else f_req → F_ACC.
  - else IDLE.
- On a decision, ram_addr and ram_wdata are loaded from the winner's inputs.
- F_ACC → F_RESP; D_RD → D_RESP.
- Grant pulses:
  - f_gnt = 1 in F_ACC.
  - d_gnt = 1 in D_RD and D_WR.
- ram_w_en = 1 in D_WR, gated by rst_n: never asserted while rst_n = 0.
- F_RESP: f_rvalid = 1 and f_rdata is captured from ram_rdata. D_RESP does the same on the data side.
- Requesters drop req the cycle after seeing gnt, unless issuing a new request.
- Reset values:
  - state IDLE.
  - f_gnt, d_gnt, f_rvalid, d_rvalid, ram_w_en = 0.
  - ram_addr, ram_wdata, f_rdata, d_rdata = 0.
  - starvation counter 0.
- Reset mid-operation: any in-flight read is dropped (no rvalid). A write whose D_WR cycle coincides with rst_n = 0 is suppressed.
- Simultaneous f_req and d_req: data wins, except when the guard forces fetch (see Configuration).

## Timing
- Read: request sampled at edge n; gnt and RAM address in cycle n+1; rvalid and rdata in cycle n+2.
- Write: request sampled at edge n; d_gnt and ram_w_en in cycle n+1; the next decision is at the end of cycle n+1.
- Back-to-back reads: one per 2 cycles, because RESP overlaps the next decision. Back-to-back writes: one per cycle.
- From IDLE with both requests held continuously (no guard): data is serviced every access and fetch never wins.
- All outputs are registered or decoded directly from state; there is no combinational path from req to gnt.

## Configuration
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments on each contested decision won by data.
  - When the counter equals STARVE_LIMIT, the next contested decision goes to fetch and the counter clears.
  - Any fetch win clears the counter.
  - Uncontested decisions leave the counter unchanged.
- Undefined: strict data priority, no counter hardware, and STARVE_LIMIT is unused.

## Test plan
- Reset hold 2 cycles with f_req = 1: all outputs 0, no gnt. After release, f_addr = 0x05 with RAM[5] = 0xA0B1 → f_gnt at +1, f_rvalid with f_rdata = 0xA0B1 at +2.
- d_req, d_we = 1, d_addr = 0x10, d_wdata = 0x1234 → d_gnt and ram_w_en for one cycle. A following data read of 0x10 → d_rvalid with d_rdata = 0x1234.
- f_req and d_req (read of 0x20) raised in the same cycle → d_gnt first; f_gnt at the next decision (2 cycles later); both rvalids carry the correct data.
- Guard defined, STARVE_LIMIT = 4, both requesters held continuously with back-to-back data reads → exactly 4 d_gnt, then 1 f_gnt, repeating. Guard undefined → f_gnt never asserts.
- rst_n low during the D_WR cycle of a write of 0xFFFF to 0x30 → ram_w_en stays 0 and RAM[0x30] is unchanged.
- rst_n low during F_ACC → no f_rvalid is ever produced for that request, and the arbiter restarts in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store data paths.
// Define MEM_ARB_STARVE_GUARD_EN to bound how long fetch can lose to data.
module mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_w_en,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    F_ACC,
    D_RD,
    D_WR,
    F_RESP,
    D_RESP
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;
  logic              fetch_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             decide;
  logic             contested;

  always_comb begin
    decide     = (state == IDLE) || (state == F_RESP) ||
                 (state == D_RESP) || (state == D_WR);
    contested  = f_req && d_req;
    fetch_wins = f_req && (!d_req || (starve_cnt == CNT_W'(STARVE_LIMIT)));
  end

  // Counts consecutive contested losses by fetch; any fetch win restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (decide) begin
      if (fetch_wins) begin
        starve_cnt <= '0;
      end else if (contested) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  always_comb begin
    fetch_wins = f_req && !d_req;
  end
`endif

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    case (state)
      F_ACC:   state_nx = F_RESP;
      D_RD:    state_nx = D_RESP;
      default: begin
        // IDLE, F_RESP, D_RESP and D_WR all end with an arbitration decision.
        if (fetch_wins) begin
          state_nx = F_ACC;
          addr_nx  = f_addr;
        end else if (d_req) begin
          state_nx = d_we ? D_WR : D_RD;
          addr_nx  = d_addr;
          wdata_nx = d_wdata;
        end else begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state   <= state_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      if (state == F_RESP) begin
        f_rdata_q <= ram_rdata;
      end
      if (state == D_RESP) begin
        d_rdata_q <= ram_rdata;
      end
    end
  end

  // Response data passes straight through in the RESP cycle, then holds.
  always_comb begin
    f_gnt     = (state == F_ACC);
    d_gnt     = (state == D_RD) || (state == D_WR);
    ram_w_en  = (state == D_WR) && rst_n;
    f_rvalid  = (state == F_RESP) && rst_n;
    d_rvalid  = (state == D_RESP) && rst_n;
    f_rdata   = (state == F_RESP) ? ram_rdata : f_rdata_q;
    d_rdata   = (state == D_RESP) ? ram_rdata : d_rdata_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-schedule reference model and
// directed scenarios. Honours MEM_ARB_STARVE_GUARD_EN like the design.
module tb_mem_arbiter;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              rst_n;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_w_en;
  logic [DATA_W-1:0] ram_rdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_w_en (ram_w_en),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    logic [DATA_W-1:0] v;
    v = DATA_W'(i * 257) ^ 16'h1357;
    if (i == 16'h05) v = 16'hA0B1;
    if (i == 16'h20) v = 16'h5A5A;
    if (i == 16'h30) v = 16'h0C0C;
    return v;
  endfunction

  // Synchronous-read RAM seen by the DUT
  logic [DATA_W-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_w_en) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each decision schedules grant/response/next-decision
  // edges from the timing rules; the shadow memory tracks expected RAM contents.
  logic [DATA_W-1:0] shadow [256];
  int                edge_n = 0;
  int                next_dec = 1;
  int                rd_owner = 0;   // 0 none, 1 fetch, 2 data
  int                rd_edge = 0;
  logic [ADDR_W-1:0] rd_addr;
  bit                wr_pend = 0;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  int                starve = 0;
  bit                model_live = 0;
  bit                ef_gnt, ed_gnt, ew_en, ef_rv, ed_rv;
  logic [DATA_W-1:0] ef_rdata, ed_rdata, ewdata;
  logic [ADDR_W-1:0] eaddr;

  always @(posedge clk) begin
    bit fw;
    bit contested;
    edge_n++;
    ef_gnt = 0; ed_gnt = 0; ew_en = 0; ef_rv = 0; ed_rv = 0;
    if (!rst_n) begin
      eaddr = '0; ewdata = '0; ef_rdata = '0; ed_rdata = '0;
      starve = 0; rd_owner = 0; wr_pend = 0; next_dec = edge_n + 1;
    end else begin
      if (wr_pend) begin
        shadow[wr_addr] = wr_data;
        wr_pend = 0;
      end
      if (rd_owner != 0 && rd_edge == edge_n) begin
        if (rd_owner == 1) begin ef_rv = 1; ef_rdata = shadow[rd_addr]; end
        else               begin ed_rv = 1; ed_rdata = shadow[rd_addr]; end
        rd_owner = 0;
      end
      if (edge_n == next_dec) begin
        contested = f_req && d_req;
        fw = f_req && !d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (contested && starve == STARVE_LIMIT) fw = 1;
        if (fw) starve = 0;
        else if (contested) starve++;
`endif
        if (fw) begin
          ef_gnt = 1; eaddr = f_addr;
          rd_owner = 1; rd_addr = f_addr; rd_edge = edge_n + 1;
          next_dec = edge_n + 2;
        end else if (d_req) begin
          ed_gnt = 1; eaddr = d_addr; ewdata = d_wdata;
          if (d_we) begin
            ew_en = 1; wr_pend = 1; wr_addr = d_addr; wr_data = d_wdata;
            next_dec = edge_n + 1;
          end else begin
            rd_owner = 2; rd_addr = d_addr; rd_edge = edge_n + 1;
            next_dec = edge_n + 2;
          end
        end else begin
          next_dec = edge_n + 1;
        end
      end
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("f_gnt",     32'(f_gnt),     32'(ef_gnt));
      chk("d_gnt",     32'(d_gnt),     32'(ed_gnt));
      chk("ram_w_en",  32'(ram_w_en),  32'(ew_en && rst_n));
      chk("f_rvalid",  32'(f_rvalid),  32'(ef_rv && rst_n));
      chk("d_rvalid",  32'(d_rvalid),  32'(ed_rv && rst_n));
      chk("f_rdata",   32'(f_rdata),   32'(ef_rdata));
      chk("d_rdata",   32'(d_rdata),   32'(ed_rdata));
      chk("ram_addr",  32'(ram_addr),  32'(eaddr));
      chk("ram_wdata", 32'(ram_wdata), 32'(ewdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit fetch, input string name);
    int unsigned n = 0;
    bit got = 0;
    while (!got && n < 16) begin
      step();
      n++;
      if (fetch ? f_gnt : d_gnt) got = 1;
    end
    chk({name, "_gnt_seen"}, 32'(got), 32'd1);
    if (fetch) f_req = 0;
    else       d_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int seq[$];
    int rv_cnt;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = init_val(i);
      shadow[i]  = init_val(i);
    end
    rst_n = 0; f_req = 1; f_addr = 8'h05;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // Reset held two cycles with a fetch pending
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_f_gnt",    32'(f_gnt),    32'd0);
      chk("rst_d_gnt",    32'(d_gnt),    32'd0);
      chk("rst_ram_w_en", 32'(ram_w_en), 32'd0);
      chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_f_rdata",  32'(f_rdata),  32'd0);
    end
    rst_n = 1;
    step();
    chk("fetch1_gnt",  32'(f_gnt),    32'd1);
    chk("fetch1_addr", 32'(ram_addr), 32'h05);
    f_req = 0;
    step();
    chk("fetch1_rvalid", 32'(f_rvalid), 32'd1);
    chk("fetch1_rdata",  32'(f_rdata),  32'hA0B1);
    step();
    chk("fetch1_hold", 32'(f_rdata), 32'hA0B1);

    // Data write then read-back
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 16'h1234;
    wait_gnt(0, "wr10");
    chk("wr10_w_en", 32'(ram_w_en), 32'd1);
    step();
    chk("wr10_w_en_off", 32'(ram_w_en), 32'd0);
    chk("wr10_ram",      32'(ram_mem[8'h10]), 32'h1234);
    d_req = 1; d_we = 0; d_wdata = 16'h0000;
    wait_gnt(0, "rd10");
    step();
    chk("rd10_rvalid", 32'(d_rvalid), 32'd1);
    chk("rd10_rdata",  32'(d_rdata),  32'h1234);

    // Simultaneous requests: data first, fetch at the next decision
    f_req = 1; f_addr = 8'h05; d_req = 1; d_we = 0; d_addr = 8'h20;
    step();
    chk("both_d_first", 32'(d_gnt), 32'd1);
    chk("both_f_wait",  32'(f_gnt), 32'd0);
    d_req = 0;
    step();
    chk("both_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("both_d_rdata",  32'(d_rdata),  32'h5A5A);
    step();
    chk("both_f_gnt", 32'(f_gnt), 32'd1);
    f_req = 0;
    step();
    chk("both_f_rvalid", 32'(f_rvalid), 32'd1);
    chk("both_f_rdata",  32'(f_rdata),  32'hA0B1);

    // Reset lands on the D_WR cycle: write must be suppressed
    d_req = 1; d_we = 1; d_addr = 8'h30; d_wdata = 16'hFFFF;
    wait_gnt(0, "wr30");
    rst_n = 0;
    #1;
    chk("wr30_w_en_gated", 32'(ram_w_en), 32'd0);
    step();
    chk("wr30_ram_kept", 32'(ram_mem[8'h30]), 32'h0C0C);
    rst_n = 1;
    step();

    // Reset during F_ACC: the fetch response is dropped
    f_req = 1; f_addr = 8'h05;
    wait_gnt(1, "facc");
    rst_n = 0;
    step();
    rst_n = 1;
    rv_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (f_rvalid) rv_cnt++;
    end
    chk("facc_no_rvalid", 32'(rv_cnt), 32'd0);
    f_req = 1; f_addr = 8'h21;
    step();
    chk("restart_f_gnt", 32'(f_gnt), 32'd1);
    f_req = 0;
    step();
    chk("restart_f_rdata", 32'(f_rdata), 32'(init_val(8'h21)));

    // Both requesters held continuously with back-to-back data reads
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    f_req = 1; f_addr = 8'h05; d_req = 1; d_we = 0; d_addr = 8'h20;
    for (int c = 0; c < 20; c++) begin
      step();
      if (d_gnt) seq.push_back(0);
      if (f_gnt) seq.push_back(1);
    end
    chk("starve_grants", 32'(seq.size()), 32'd10);
    for (int i = 0; i < 10 && i < seq.size(); i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk($sformatf("starve_seq%0d", i), 32'(seq[i]), (i % 5 == 4) ? 32'd1 : 32'd0);
`else
      chk($sformatf("starve_seq%0d", i), 32'(seq[i]), 32'd0);
`endif
    end
    f_req = 0; d_req = 0;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
